// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, NOP word
// and sequential PC step.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
  localparam logic [31:0] PC_INC      = 32'd4;

  // Sequential successor; wraps naturally at 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/if_fetch_stage_skid_buf.sv
// One-entry {instr, pc} holding buffer that catches a memory response which
// arrives while decode is stalled.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_clr,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  // Clear wins over load so a flush never leaves stale data behind.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: drives a ready/request instruction memory port and
// fills the IF/ID register, handling stalls, redirects and in-flight drains.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        misalign_err
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_req_addr;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc_out;
  logic         r_valid;

  logic [31:0]  w_tgt;
  logic [31:0]  w_pc_inc;
  logic         w_buf_load;
  logic         w_buf_clr;
  logic         w_buf_valid;
  logic [31:0]  w_buf_instr;
  logic [31:0]  w_buf_pc;

  assign w_tgt    = {redirect_target[31:2], 2'b00};
  assign w_pc_inc = next_pc(r_pc);

  assign w_buf_load = (r_state == ST_REQ) && imem_ready && stall && !redirect_en;
  assign w_buf_clr  = redirect_en || ((r_state == ST_HOLD) && !stall);

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_buf_load),
    .i_clr   (w_buf_clr),
    .i_instr (imem_rdata),
    .i_pc    (r_req_addr),
    .o_valid (w_buf_valid),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_pc_out   <= 32'd0;
      r_valid    <= 1'b0;
    end else if (redirect_en) begin
      r_pc    <= w_tgt;
      r_valid <= 1'b0;
      // An unanswered request must complete at its original address first.
      case (r_state)
        ST_REQ: begin
          if (imem_ready) r_req_addr <= w_tgt;
          else            r_state    <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (imem_ready) begin
            r_state    <= ST_REQ;
            r_req_addr <= w_tgt;
          end
        end
        default: begin
          r_state    <= ST_REQ;
          r_req_addr <= w_tgt;
        end
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_REQ;
          r_req_addr <= r_pc;
        end
        ST_REQ: begin
          if (imem_ready) begin
            r_pc <= w_pc_inc;
            if (stall) begin
              r_state <= ST_HOLD;
            end else begin
              r_instr    <= imem_rdata;
              r_pc_out   <= r_req_addr;
              r_valid    <= 1'b1;
              r_req_addr <= w_pc_inc;
            end
          end else if (!stall) begin
            r_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            r_instr    <= w_buf_instr;
            r_pc_out   <= w_buf_pc;
            r_valid    <= w_buf_valid;
            r_state    <= ST_REQ;
            r_req_addr <= r_pc;
          end
        end
        default: begin
          if (imem_ready) begin
            r_state    <= ST_REQ;
            r_req_addr <= r_pc;
          end
        end
      endcase
    end
  end

  assign imem_req     = (r_state == ST_REQ) || (r_state == ST_DRAIN);
  assign imem_addr    = r_req_addr;
  assign instr_valid  = r_valid;
  assign instr_out    = r_valid ? r_instr : NOP_INSTR;
  assign pc_out       = r_pc_out;
  assign misalign_err = rst_n && redirect_en && (redirect_target[1:0] != 2'b00);

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, streaming, wait states, stall/HOLD,
// redirect with drain, misaligned redirect, PC wrap and mid-request reset.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_target;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .stall           (stall),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .instr_valid     (instr_valid),
    .misalign_err    (misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // IF/ID triple check
  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins,
                          input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(instr_valid), 32'(v));
    chk({tag, "_instr"}, instr_out, ins);
    chk({tag, "_pc"},    pc_out,    pc);
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; redirect_en = 1'b0; redirect_target = 32'h0;
    tick(); tick();

    // reset state
    chk_ifid("rst", 1'b0, 32'h0000_0013, 32'h0);
    chk("rst_req",   32'(imem_req), 32'h0);
    chk("rst_mis",   32'(misalign_err), 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

    // streaming with ready tied high
    rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0050_0093;
    tick();
    chk("s1_req", 32'(imem_req), 32'h1);
    chk("s1_addr0", imem_addr, 32'h0);
    chk("s1_v0", 32'(instr_valid), 32'h0);
    tick();
    chk_ifid("s1_a", 1'b1, 32'h0050_0093, 32'h0);
    chk("s1_addr4", imem_addr, 32'h4);
    imem_rdata = 32'h00A0_0113;
    tick();
    chk_ifid("s1_b", 1'b1, 32'h00A0_0113, 32'h4);
    chk("s1_addr8", imem_addr, 32'h8);

    // three wait states at 0x8
    imem_ready = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_ifid("ws", 1'b0, 32'h0000_0013, 32'h4);
      chk("ws_addr", imem_addr, 32'h8);
      chk("ws_req",  32'(imem_req), 32'h1);
    end
    imem_ready = 1'b1; imem_rdata = 32'h0010_0193;
    tick();
    chk_ifid("ws_done", 1'b1, 32'h0010_0193, 32'h8);
    chk("ws_addr_c", imem_addr, 32'hC);

    // stall while response for 0xC arrives
    stall = 1'b1; imem_rdata = 32'h0020_0213;
    tick();
    chk_ifid("st1", 1'b1, 32'h0010_0193, 32'h8);
    chk("st1_state", 32'(dut.r_state), 32'(ST_HOLD));
    chk("st1_req", 32'(imem_req), 32'h0);
    imem_rdata = 32'hBAD1_BAD1;
    tick();
    chk_ifid("st2", 1'b1, 32'h0010_0193, 32'h8);
    chk("st2_state", 32'(dut.r_state), 32'(ST_HOLD));
    stall = 1'b0;
    tick();
    chk_ifid("st_rel", 1'b1, 32'h0020_0213, 32'hC);
    chk("st_rel_state", 32'(dut.r_state), 32'(ST_REQ));
    chk("st_rel_addr", imem_addr, 32'h10);

    // redirect to 0x100 while 0x10 is outstanding
    imem_ready = 1'b0; redirect_en = 1'b1; redirect_target = 32'h100;
    #1;
    chk("rd_mis0", 32'(misalign_err), 32'h0);
    tick();
    redirect_en = 1'b0;
    chk_ifid("rd_flush", 1'b0, 32'h0000_0013, 32'hC);
    chk("rd_state", 32'(dut.r_state), 32'(ST_DRAIN));
    chk("rd_addr", imem_addr, 32'h10);
    chk("rd_req", 32'(imem_req), 32'h1);
    tick();
    chk("rd_state2", 32'(dut.r_state), 32'(ST_DRAIN));
    chk("rd_addr2", imem_addr, 32'h10);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rd_drop_v", 32'(instr_valid), 32'h0);
    chk("rd_drop_i", instr_out, 32'h0000_0013);
    chk("rd_new_addr", imem_addr, 32'h100);
    imem_rdata = 32'h0030_0293;
    tick();
    chk_ifid("rd_first", 1'b1, 32'h0030_0293, 32'h100);
    chk("rd_addr104", imem_addr, 32'h104);

    // misaligned redirect to 0x102
    redirect_en = 1'b1; redirect_target = 32'h102;
    #1;
    chk("mis_pulse", 32'(misalign_err), 32'h1);
    tick();
    redirect_en = 1'b0;
    #1;
    chk("mis_clear", 32'(misalign_err), 32'h0);
    chk("mis_v", 32'(instr_valid), 32'h0);
    chk("mis_addr", imem_addr, 32'h100);
    imem_rdata = 32'h0040_0313;
    tick();
    chk_ifid("mis_fetch", 1'b1, 32'h0040_0313, 32'h100);

    // PC wrap
    redirect_en = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_en = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    imem_rdata = 32'h0050_0393;
    tick();
    chk_ifid("wr_fetch", 1'b1, 32'h0050_0393, 32'hFFFF_FFFC);
    chk("wr_next", imem_addr, 32'h0);

    // redirect together with stall flushes IF/ID
    stall = 1'b1; redirect_en = 1'b1; redirect_target = 32'h200;
    tick();
    stall = 1'b0; redirect_en = 1'b0;
    chk("rs_v", 32'(instr_valid), 32'h0);
    chk("rs_addr", imem_addr, 32'h200);
    chk("rs_state", 32'(dut.r_state), 32'(ST_REQ));

    // reset while a request is pending
    imem_ready = 1'b0; rst_n = 1'b0;
    tick();
    chk("mr_req", 32'(imem_req), 32'h0);
    chk("mr_addr", imem_addr, 32'h0);
    chk("mr_state", 32'(dut.r_state), 32'(ST_IDLE));
    rst_n = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0060_0413;
    tick();
    chk("mr_req1", 32'(imem_req), 32'h1);
    chk("mr_addr1", imem_addr, 32'h0);
    tick();
    chk_ifid("mr_fetch", 1'b1, 32'h0060_0413, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
